// File: rtl/lzrw1_compressor_core.sv
// lzrw1_compressor_core: streaming LZRW1-style compressor.
// Consumes one byte per handshake and emits literal/copy items tagged with a
// control bit, in the item format the matching decompressor consumes.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_FILL      | accepting bytes into the 3-byte lookahead
// S_LOOKUP    | hash lookahead, probe and update table, 3-byte compare
// S_MATCH     | extending a copy one accepted byte at a time
// S_EMIT_LIT  | holding a literal item until out_ready
// S_EMIT_COPY | holding a copy item until out_ready
// S_FLUSH     | draining leftover lookahead bytes as literals
// S_DONE      | one-cycle done pulse, clears per-stream state
module lzrw1_compressor_core #(
  parameter int HISTORY_SIZE = 4096,
  parameter int HASH_BITS    = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  input  logic        data_in_last,
  output logic        compressor_busy,
  output logic [15:0] data_out,
  output logic        control_word_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  localparam int AW = $clog2(HISTORY_SIZE);
  localparam int TS = 1 << HASH_BITS;
  // Longest copy (18) must still fit inside the window behind the write pointer.
  localparam logic [AW-1:0] MAX_DIST = AW'(HISTORY_SIZE - 18);

  typedef enum logic [2:0] {
    S_FILL, S_LOOKUP, S_MATCH, S_EMIT_LIT, S_EMIT_COPY, S_FLUSH, S_DONE
  } state_t;

  state_t              state;
  logic [7:0]          hist [HISTORY_SIZE];
  logic [AW-1:0]       tbl_pos [TS];
  logic [TS-1:0]       tbl_vld;
  logic [AW-1:0]       pos;
  logic [AW-1:0]       cand;
  logic [AW-1:0]       off;
  logic [7:0]          la0, la1, la2;
  logic [1:0]          la_cnt;
  logic [4:0]          len;
  logic                last_la;    // last byte of the stream sits in the lookahead
  logic                last_done;  // last byte was absorbed by the copy being emitted

  logic [11:0]          hash_w;
  logic [HASH_BITS-1:0] h;
  logic [AW-1:0]        p0;
  logic [AW-1:0]        lk_cand;
  logic [AW-1:0]        lk_dist;
  logic                 lk_match;
  logic [AW-1:0]        mt_rd;
  logic                 mt_eq;
  logic [4:0]           len_inc;
  logic                 accept;

  assign hash_w   = {4'h0, la0} ^ {2'b00, la1, 2'b00} ^ {la2, 4'h0};
  assign h        = HASH_BITS'(hash_w);
  // In LOOKUP the lookahead is always full, so b0 sits three bytes behind pos.
  assign p0       = pos - AW'(3);
  assign lk_cand  = tbl_pos[h];
  assign lk_dist  = p0 - lk_cand;
  // Stale or colliding entries are harmless: the byte compare rejects them.
  assign lk_match = tbl_vld[h] && (lk_dist != '0) && (lk_dist <= MAX_DIST) &&
                    (hist[lk_cand] == la0) &&
                    (hist[lk_cand + AW'(1)] == la1) &&
                    (hist[lk_cand + AW'(2)] == la2);
  // Offset >= 1 keeps this read strictly behind the byte written this cycle.
  assign mt_rd    = cand + AW'(len);
  assign mt_eq    = (hist[mt_rd] == data_in);
  assign len_inc  = len + 5'd1;
  assign accept   = data_in_valid && !compressor_busy;

  // History and hash-position storage; validity lives in tbl_vld, so no reset.
  always_ff @(posedge clock) begin
    if (accept) hist[pos] <= data_in;
    if (state == S_LOOKUP) tbl_pos[h] <= p0;
  end

  // Main sequencer: lookahead, match tracking and registered item outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_FILL;
      pos              <= '0;
      cand             <= '0;
      off              <= '0;
      la0              <= '0;
      la1              <= '0;
      la2              <= '0;
      la_cnt           <= '0;
      len              <= '0;
      tbl_vld          <= '0;
      last_la          <= 1'b0;
      last_done        <= 1'b0;
      data_out         <= '0;
      control_word_out <= 1'b0;
      out_valid        <= 1'b0;
      done             <= 1'b0;
      compressor_busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) pos <= pos + AW'(1);
      case (state)
        S_FILL: begin
          if (data_in_valid) begin
            case (la_cnt)
              2'd0:    la0 <= data_in;
              2'd1:    la1 <= data_in;
              default: la2 <= data_in;
            endcase
            la_cnt <= la_cnt + 2'd1;
            if (la_cnt == 2'd2) begin
              state           <= S_LOOKUP;
              compressor_busy <= 1'b1;
              last_la         <= data_in_last;
            end else if (data_in_last) begin
              state            <= S_FLUSH;
              compressor_busy  <= 1'b1;
              last_la          <= 1'b1;
              out_valid        <= 1'b1;
              control_word_out <= 1'b0;
              data_out         <= {8'h00, (la_cnt == 2'd0) ? data_in : la0};
            end
          end
        end
        S_LOOKUP: begin
          tbl_vld[h] <= 1'b1;
          if (lk_match) begin
            cand   <= lk_cand;
            off    <= lk_dist;
            len    <= 5'd3;
            la_cnt <= 2'd0;
            if (last_la) begin
              // Stream ends exactly on the third matched byte.
              state            <= S_EMIT_COPY;
              last_la          <= 1'b0;
              last_done        <= 1'b1;
              out_valid        <= 1'b1;
              control_word_out <= 1'b1;
              data_out         <= {4'd0, 12'(lk_dist)};
            end else begin
              state           <= S_MATCH;
              compressor_busy <= 1'b0;
            end
          end else begin
            state            <= S_EMIT_LIT;
            out_valid        <= 1'b1;
            control_word_out <= 1'b0;
            data_out         <= {8'h00, la0};
            la0              <= la1;
            la1              <= la2;
            la_cnt           <= 2'd2;
          end
        end
        S_MATCH: begin
          if (data_in_valid) begin
            if (mt_eq) begin
              len <= len_inc;
              if (len_inc == 5'd18 || data_in_last) begin
                state            <= S_EMIT_COPY;
                compressor_busy  <= 1'b1;
                last_done        <= data_in_last;
                out_valid        <= 1'b1;
                control_word_out <= 1'b1;
                data_out         <= {4'(len_inc - 5'd3), 12'(off)};
              end
            end else begin
              la0              <= data_in;
              la_cnt           <= 2'd1;
              last_la          <= data_in_last;
              state            <= S_EMIT_COPY;
              compressor_busy  <= 1'b1;
              out_valid        <= 1'b1;
              control_word_out <= 1'b1;
              data_out         <= {4'(len - 5'd3), 12'(off)};
            end
          end
        end
        S_EMIT_LIT, S_EMIT_COPY: begin
          if (out_ready) begin
            if (last_done) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (last_la) begin
              state            <= S_FLUSH;
              control_word_out <= 1'b0;
              data_out         <= {8'h00, la0};
            end else begin
              state           <= S_FILL;
              out_valid       <= 1'b0;
              compressor_busy <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            if (la_cnt > 2'd1) begin
              data_out <= {8'h00, la1};
              la0      <= la1;
              la1      <= la2;
              la_cnt   <= la_cnt - 2'd1;
            end else begin
              state     <= S_DONE;
              la_cnt    <= 2'd0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state           <= S_FILL;
          compressor_busy <= 1'b0;
          pos             <= '0;
          la_cnt          <= 2'd0;
          len             <= '0;
          tbl_vld         <= '0;
          last_la         <= 1'b0;
          last_done       <= 1'b0;
        end
        default: begin
          state           <= S_FILL;
          compressor_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
